// File: rtl/eq_lock_tracker.sv
// eq_lock_tracker: debounces the registered equality flag from the comparator
// stage into a lock indication with hysteresis. It also produces one-cycle
// lock/unlock event pulses and keeps saturating statistics counters.
module eq_lock_tracker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             eq_w,
  input  logic             enable,
  input  logic             clear,
  output logic             locked,
  output logic             lock_evt,
  output logic             unlock_evt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] lock_cnt
);

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10,
    HOLD    = 2'b11
  } stateT;

  // Thresholds are widened by one bit so that run+1 / miss+1 cannot wrap
  // before the comparison.
  localparam logic [8:0] LockTarget   = 9'(LOCK_CNT);
  localparam logic [8:0] UnlockTarget = 9'(UNLOCK_CNT);

  stateT            state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [7:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             lockEvt_q, lockEvt_d;
  logic             unlockEvt_q, unlockEvt_d;
  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
  logic [CNT_W-1:0] lockCnt_q, lockCnt_d;

  logic [8:0] runNext;
  logic [8:0] missNext;

  assign runNext  = {1'b0, run_q} + 9'd1;
  assign missNext = {1'b0, miss_q} + 9'd1;

  // State register plus all registered outputs; reset clears everything at
  // once, so a reset exit from lock never produces an unlock event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      lockEvt_q   <= 1'b0;
      unlockEvt_q <= 1'b0;
      matchCnt_q  <= '0;
      lockCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      lockEvt_q   <= lockEvt_d;
      unlockEvt_q <= unlockEvt_d;
      matchCnt_q  <= matchCnt_d;
      lockCnt_q   <= lockCnt_d;
    end
  end

  // Next-state logic: run/miss restart on every state change, and dropping
  // enable forces the tracker back to SEARCH from anywhere.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    if (!enable) begin
      state_d = SEARCH;
      run_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (eq_w) begin
            state_d = ACQUIRE;
            run_d   = 8'd1;
            miss_d  = '0;
          end
        end
        ACQUIRE: begin
          if (eq_w) begin
            if (runNext == LockTarget) begin
              state_d = LOCKED;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              run_d = runNext[7:0];
            end
          end else begin
            state_d = SEARCH;
            run_d   = '0;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          if (!eq_w) begin
            state_d = HOLD;
            run_d   = '0;
            miss_d  = 8'd1;
          end
        end
        HOLD: begin
          if (eq_w) begin
            state_d = LOCKED;
            run_d   = '0;
            miss_d  = '0;
          end else if (missNext == UnlockTarget) begin
            state_d = SEARCH;
            run_d   = '0;
            miss_d  = '0;
          end else begin
            miss_d = missNext[7:0];
          end
        end
        default: begin
          state_d = SEARCH;
          run_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // Output logic: events come from the transition being taken, and the
  // statistics counters saturate, with clear taking priority over increments.
  always_comb begin
    locked_d    = (state_d == LOCKED) || (state_d == HOLD);
    lockEvt_d   = (state_q == ACQUIRE) && (state_d == LOCKED);
    unlockEvt_d = ((state_q == LOCKED) || (state_q == HOLD)) && (state_d == SEARCH);

    matchCnt_d = matchCnt_q;
    lockCnt_d  = lockCnt_q;
    if (clear) begin
      matchCnt_d = '0;
      lockCnt_d  = '0;
    end else begin
      if (enable && eq_w && (matchCnt_q != {CNT_W{1'b1}})) begin
        matchCnt_d = matchCnt_q + 1'b1;
      end
      if (lockEvt_d && (lockCnt_q != {CNT_W{1'b1}})) begin
        lockCnt_d = lockCnt_q + 1'b1;
      end
    end
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign lock_evt   = lockEvt_q;
  assign unlock_evt = unlockEvt_q;
  assign match_cnt  = matchCnt_q;
  assign lock_cnt   = lockCnt_q;

endmodule

// File: tb/tb_eq_lock_tracker.sv
// Directed testbench for eq_lock_tracker with LOCK_CNT=4, UNLOCK_CNT=2,
// CNT_W=8. Expected values are hand-computed for each vector.
module tb_eq_lock_tracker;

  logic       clk;
  logic       reset;
  logic       eqW;
  logic       enable;
  logic       clear;
  logic       locked;
  logic       lockEvt;
  logic       unlockEvt;
  logic [1:0] state;
  logic [7:0] matchCnt;
  logic [7:0] lockCnt;

  int checkCount = 0;
  int passCount  = 0;

  eq_lock_tracker #(
    .LOCK_CNT(4),
    .UNLOCK_CNT(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .eq_w(eqW),
    .enable(enable),
    .clear(clear),
    .locked(locked),
    .lock_evt(lockEvt),
    .unlock_evt(unlockEvt),
    .state(state),
    .match_cnt(matchCnt),
    .lock_cnt(lockCnt)
  );

  // 10-unit free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports one check
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Checks every output against the expected set
  task automatic checkAll(input string tag, input int expState, input int expLocked,
                          input int expLockEvt, input int expUnlockEvt,
                          input int expMatch, input int expLockCnt);
    checkOutput({tag, ".state"},      32'(state),     32'(expState));
    checkOutput({tag, ".locked"},     32'(locked),    32'(expLocked));
    checkOutput({tag, ".lock_evt"},   32'(lockEvt),   32'(expLockEvt));
    checkOutput({tag, ".unlock_evt"}, 32'(unlockEvt), 32'(expUnlockEvt));
    checkOutput({tag, ".match_cnt"},  32'(matchCnt),  32'(expMatch));
    checkOutput({tag, ".lock_cnt"},   32'(lockCnt),   32'(expLockCnt));
  endtask

  // Drives one set of inputs across a rising edge and settles 1 unit after it
  task automatic applyStimulus(input logic eqVal, input logic enVal, input logic clrVal);
    eqW    = eqVal;
    enable = enVal;
    clear  = clrVal;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [7:0] pattern;
    int         expSt [8];

    reset  = 1'b1;
    eqW    = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    #3;
    checkAll("reset_async", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle with no matches
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkAll("idle", 0, 0, 0, 0, 0, 0);
    end

    // Clean acquisition: 4 matches
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("acq1", 1, 0, 0, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("acq2", 1, 0, 0, 0, 2, 0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("acq3", 1, 0, 0, 0, 3, 0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("acq4", 2, 1, 1, 0, 4, 1);
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("acq5", 2, 1, 0, 0, 5, 1);

    // Hysteresis from LOCKED: 0,1,0,0
    applyStimulus(1'b0, 1'b1, 1'b0); checkAll("hys1", 3, 1, 0, 0, 5, 1);
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("hys2", 2, 1, 0, 0, 6, 1);
    applyStimulus(1'b0, 1'b1, 1'b0); checkAll("hys3", 3, 1, 0, 0, 6, 1);
    applyStimulus(1'b0, 1'b1, 1'b0); checkAll("hys4", 0, 0, 0, 1, 6, 1);
    applyStimulus(1'b0, 1'b1, 1'b0); checkAll("hys5", 0, 0, 0, 0, 6, 1);

    // Clear only the counters
    applyStimulus(1'b0, 1'b1, 1'b1); checkAll("clr_idle", 0, 0, 0, 0, 0, 0);

    // Broken run 1,1,1,0 then a full run of 4
    pattern = 8'b1111_0111;
    expSt   = '{1, 1, 1, 0, 1, 1, 1, 2};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(pattern[i], 1'b1, 1'b0);
      checkOutput("broken.state", 32'(state), 32'(expSt[i]));
    end
    checkAll("broken_end", 2, 1, 1, 0, 7, 1);

    // Dropping enable in LOCKED
    applyStimulus(1'b1, 1'b0, 1'b0); checkAll("dis1", 0, 0, 0, 1, 7, 1);
    applyStimulus(1'b1, 1'b0, 1'b0); checkAll("dis2", 0, 0, 0, 0, 7, 1);

    // Long run: relock and saturate match_cnt
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (i == 247) checkOutput("sat_reach", 32'(matchCnt), 32'd255);
      if (i == 248) checkOutput("sat_hold1", 32'(matchCnt), 32'd255);
    end
    checkAll("sat_end", 2, 1, 0, 0, 255, 2);

    // Clear beats a simultaneous increment; FSM untouched
    applyStimulus(1'b1, 1'b1, 1'b1); checkAll("clr_sat", 2, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkAll("clr_after", 2, 1, 0, 0, 1, 0);

    // Async reset while LOCKED, between edges
    reset = 1'b1;
    #1;
    checkAll("rst_mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0); checkAll("rst_after", 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
